nes_joypad_emu: RTL and testbench
=================================

# nes_joypad_emu

Controller-side responder for the NES serial joypad protocol, emulating a CD4021-based standard controller. It takes the console's latch and clock strobes and returns button state one bit per clock on the data line. Local button inputs supply the state, and an optional turbo modulates A and B. It sits at the joypad connector opposite the rp2a03 joypad initiator, so a board can act as a controller for an external console or be looped back to the internal CPU for self-test.

## Interface
Parameters:
- INVERT_OUT, 1: when 1, `jp_data_out` = ~logical bit (connector level: pressed = low); when 0, `jp_data_out` = logical bit.
- LATCH_ACTIVE_HIGH, 1: polarity of `jp_latch_in` that means "parallel load".
- SHIFT_ON_RISE, 1: shift on the rising edge of the synchronized `jp_clk_in` when 1, on the falling edge when 0.
- TURBO_DIV_BITS, 20: width of the turbo divider. The turbo phase toggles every 2^TURBO_DIV_BITS cycles.

Ports:
- clk, in, 1: system clock. Single clock domain.
- rst_n, in, 1: reset, asynchronous assert, active low.
- buttons_in, in, 8: pressed = 1. Bit order [0] A, [1] B, [2] Select, [3] Start, [4] Up, [5] Down, [6] Left, [7] Right. Asynchronous.
- turbo_en_in, in, 2: [0] turbo for A, [1] turbo for B. Asynchronous.
- jp_latch_in, in, 1: console latch strobe. Asynchronous.
- jp_clk_in, in, 1: console shift clock. Asynchronous.
- jp_data_out, out, 1: serial button data, polarity set by INVERT_OUT. Registered.
- frame_strobe_out, out, 1: one-cycle pulse on latch deassertion, i.e. the start of a read frame.
- shift_cnt_out, out, 4: number of shifts since the last latch, saturating at 8.

## Operation
- **Synchronization:** `jp_latch_in`, `jp_clk_in`, `buttons_in` and `turbo_en_in` each pass through a 2-FF synchronizer. The edge detector uses a third register on the synchronized clock and latch.
- **Turbo:**
  - TURBO_DIV_BITS free-running counter; `turbo_phase` toggles on wrap.
  - Effective A = A & (~turbo_en[0] | turbo_phase); B is masked the same way with turbo_en[1].
  - Other buttons pass through.
- **Load state (latch active):**
  - The shift register loads the effective buttons every cycle.
  - `shift_cnt` = 0.
  - Logical output = effective A.
  - Clock edges are ignored while latch is active.
- **Shift state (latch inactive):**
  - On each qualifying clock edge the register shifts right and bit 7 fills with 1.
  - `shift_cnt` increments, saturating at 8.
  - Logical output = register bit 0. After 8 shifts it stays 1, like an official controller.
- **frame_strobe:** asserted for one cycle on the synchronized latch active→inactive transition.
- **Simultaneous events:**
  - Latch deassertion and a clock edge in the same cycle: the latch wins, the register holds the last load, and no shift occurs that cycle.
  - Latch reassertion mid-frame: immediate reload and `shift_cnt` = 0. There is no partial-frame state.
- **Reset values:**
  - Register = 8'h00, `shift_cnt` = 0.
  - Logical output = 0, so `jp_data_out` = INVERT_OUT.
  - `frame_strobe_out` = 0.
  - Turbo counter = 0, `turbo_phase` = 1.
  - Synchronizer and edge-detect registers reset to the inactive level of their signals, so deasserting reset produces no spurious edge.

## Timing
- Pin-to-output latency: 3 clk cycles from a `jp_clk_in` or `jp_latch_in` pin transition to the updated `jp_data_out` (2 sync + 1 edge/shift register).
- Button-to-load latency: 3 cycles while latched.
- Console requirements:
  - Latch pulse and clock high/low phases ≥ 4 clk cycles each; shorter pulses may be missed.
  - The console samples data ≥ 4 clk after the preceding edge. The NES at ~12 µs per pulse vs. 40 ns clk meets this.
- `frame_strobe_out` fires 3 cycles after the latch pin deasserts.
- `shift_cnt_out` updates in the same cycle as `jp_data_out`.

## Test plan
- **Reset:** hold `rst_n` = 0 and toggle inputs -> `jp_data_out` = 1, `shift_cnt_out` = 0, `frame_strobe_out` = 0. Release reset with inputs idle -> no output change.
- **Basic frame:** `buttons_in` = 8'b1001_0101, latch high 10 cycles then low, 8 clock pulses 6 cycles each.
  - Logical sequence 1,0,1,0,1,0,0,1 on `jp_data_out` (inverted at the pin), each new bit 3 cycles after its edge.
  - `shift_cnt_out` 0→8.
  - One `frame_strobe_out` pulse.
- **Overrun:** 12 clock pulses after latch with `buttons_in` = 0 -> bits 9-12 logical 1; `shift_cnt_out` holds 8.
- **Mid-frame relatch:** after 3 shifts, assert latch -> `shift_cnt_out` = 0 and output = A within 3 cycles; clock pulses during latch cause no shift.
- **Turbo:** TURBO_DIV_BITS = 4, A held, turbo_en = 2'b01, repeated frames -> loaded A alternates in 16-cycle windows; B with turbo off stays constant.
- **Polarity/edge:** INVERT_OUT = 0, SHIFT_ON_RISE = 0 -> data non-inverted, and shifts occur only on falling clock edges.

Source files
------------

// File: rtl/nes_joypad_emu.sv
// rtl/nes_joypad_emu.sv - NES standard-controller (CD4021-style) serial responder
//
// Purpose: answers the console's latch/clock strobes with button state, one
// bit per shift clock, with optional turbo modulation on A and B.
//
// Ports:
//   clk              system clock (single domain)
//   rst_n            asynchronous active-low reset
//   buttons_in[7:0]  pressed = 1; A,B,Select,Start,Up,Down,Left,Right (async)
//   turbo_en_in[1:0] [0] turbo on A, [1] turbo on B (async)
//   jp_latch_in      console latch strobe (async)
//   jp_clk_in        console shift clock (async)
//   jp_data_out      registered serial data, inverted at the pin when INVERT_OUT
//   frame_strobe_out one-cycle pulse when the latch deasserts
//   shift_cnt_out    shifts since last latch, saturating at 8
module nes_joypad_emu #(
    parameter logic INVERT_OUT        = 1'b1,
    parameter logic LATCH_ACTIVE_HIGH = 1'b1,
    parameter logic SHIFT_ON_RISE     = 1'b1,
    parameter int   TURBO_DIV_BITS    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] buttons_in,
    input  logic [1:0] turbo_en_in,
    input  logic       jp_latch_in,
    input  logic       jp_clk_in,
    output logic       jp_data_out,
    output logic       frame_strobe_out,
    output logic [3:0] shift_cnt_out
);

    // Reset levels chosen so that releasing reset with idle pins never looks
    // like a latch deassertion or a qualifying clock edge.
    localparam logic LATCH_IDLE = ~LATCH_ACTIVE_HIGH;
    localparam logic CLK_IDLE   = SHIFT_ON_RISE;

    localparam logic [TURBO_DIV_BITS-1:0] TURBO_ONE = {{(TURBO_DIV_BITS-1){1'b0}}, 1'b1};

    logic [1:0]                r_latch_sync;
    logic [1:0]                r_clk_sync;
    logic                      r_latch_d;
    logic                      r_clk_d;
    logic [7:0]                r_btn_s1;
    logic [7:0]                r_btn_s2;
    logic [1:0]                r_turbo_s1;
    logic [1:0]                r_turbo_s2;
    logic [TURBO_DIV_BITS-1:0] r_turbo_cnt;
    logic                      r_turbo_phase;
    logic [7:0]                r_shift;
    logic [3:0]                r_shift_cnt;
    logic                      r_data_pin;
    logic                      r_frame;

    logic       w_latch_act;
    logic       w_latch_was;
    logic       w_clk_rise;
    logic       w_clk_fall;
    logic       w_shift_edge;
    logic [7:0] w_eff_btn;
    logic [7:0] w_shift_nxt;
    logic [3:0] w_cnt_nxt;

    // Synchronizers plus one extra stage on latch/clock for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch_sync <= {2{LATCH_IDLE}};
            r_clk_sync   <= {2{CLK_IDLE}};
            r_latch_d    <= LATCH_IDLE;
            r_clk_d      <= CLK_IDLE;
            r_btn_s1     <= 8'h00;
            r_btn_s2     <= 8'h00;
            r_turbo_s1   <= 2'b00;
            r_turbo_s2   <= 2'b00;
        end else begin
            r_latch_sync <= {r_latch_sync[0], jp_latch_in};
            r_clk_sync   <= {r_clk_sync[0], jp_clk_in};
            r_latch_d    <= r_latch_sync[1];
            r_clk_d      <= r_clk_sync[1];
            r_btn_s1     <= buttons_in;
            r_btn_s2     <= r_btn_s1;
            r_turbo_s1   <= turbo_en_in;
            r_turbo_s2   <= r_turbo_s1;
        end
    end

    always_comb begin
        w_latch_act  = (r_latch_sync[1] == LATCH_ACTIVE_HIGH);
        w_latch_was  = (r_latch_d == LATCH_ACTIVE_HIGH);
        w_clk_rise   = r_clk_sync[1] & ~r_clk_d;
        w_clk_fall   = ~r_clk_sync[1] & r_clk_d;
        w_shift_edge = SHIFT_ON_RISE ? w_clk_rise : w_clk_fall;
    end

    // Free-running turbo divider; phase flips each time the counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= 1'b1;
        end else begin
            r_turbo_cnt <= r_turbo_cnt + TURBO_ONE;
            if (&r_turbo_cnt) begin
                r_turbo_phase <= ~r_turbo_phase;
            end
        end
    end

    always_comb begin
        w_eff_btn    = r_btn_s2;
        w_eff_btn[0] = r_btn_s2[0] & (~r_turbo_s2[0] | r_turbo_phase);
        w_eff_btn[1] = r_btn_s2[1] & (~r_turbo_s2[1] | r_turbo_phase);
    end

    // Latch active: parallel load. First inactive cycle after latch: hold,
    // so a clock edge coinciding with latch release never shifts. Otherwise
    // shift right with 1s filling in from the top.
    always_comb begin
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_shift_cnt;
        if (w_latch_act) begin
            w_shift_nxt = w_eff_btn;
            w_cnt_nxt   = 4'd0;
        end else if (w_latch_was) begin
            w_shift_nxt = r_shift;
            w_cnt_nxt   = r_shift_cnt;
        end else if (w_shift_edge) begin
            w_shift_nxt = {1'b1, r_shift[7:1]};
            if (r_shift_cnt != 4'd8) begin
                w_cnt_nxt = r_shift_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= 8'h00;
            r_shift_cnt <= 4'd0;
            r_data_pin  <= INVERT_OUT;
            r_frame     <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_shift_cnt <= w_cnt_nxt;
            // Output register tracks the next bit 0 so data and count move together.
            r_data_pin  <= w_shift_nxt[0] ^ INVERT_OUT;
            r_frame     <= w_latch_was & ~w_latch_act;
        end
    end

    assign jp_data_out      = r_data_pin;
    assign frame_strobe_out = r_frame;
    assign shift_cnt_out    = r_shift_cnt;

endmodule

// File: tb/tb_nes_joypad_emu.sv
// tb/tb_nes_joypad_emu.sv - self-checking bench for nes_joypad_emu
module tb_nes_joypad_emu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] buttons_in;
    logic [1:0] turbo_en_in;
    logic       jp_latch_in;
    logic       jp_clk_in;

    logic       d1_data;
    logic       d1_frame;
    logic [3:0] d1_cnt;
    logic       d2_data;
    logic       d2_frame;
    logic [3:0] d2_cnt;

    int total = 0;
    int bad   = 0;
    int strobes = 0;
    int tcyc = 0;

    logic [7:0] m_val;
    int n1;
    int n2;

    nes_joypad_emu #(
        .INVERT_OUT(1'b1), .LATCH_ACTIVE_HIGH(1'b1), .SHIFT_ON_RISE(1'b1), .TURBO_DIV_BITS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .buttons_in(buttons_in), .turbo_en_in(turbo_en_in),
        .jp_latch_in(jp_latch_in), .jp_clk_in(jp_clk_in), .jp_data_out(d1_data),
        .frame_strobe_out(d1_frame), .shift_cnt_out(d1_cnt)
    );

    nes_joypad_emu #(
        .INVERT_OUT(1'b0), .LATCH_ACTIVE_HIGH(1'b1), .SHIFT_ON_RISE(1'b0), .TURBO_DIV_BITS(4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .buttons_in(buttons_in), .turbo_en_in(turbo_en_in),
        .jp_latch_in(jp_latch_in), .jp_clk_in(jp_clk_in), .jp_data_out(d2_data),
        .frame_strobe_out(d2_frame), .shift_cnt_out(d2_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n === 1'b1) tcyc <= tcyc + 1;
        if (d1_frame === 1'b1) strobes <= strobes + 1;
    end

    // Reference: the n-th bit read after a latch is button n, then 1 forever.
    function automatic logic mbit(input int n);
        return (n < 8) ? m_val[n] : 1'b1;
    endfunction

    function automatic logic [3:0] sat8(input int n);
        return (n > 8) ? 4'd8 : 4'(n);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_latch(input logic [7:0] b, input int wl);
        buttons_in = b;
        cyc(4);
        jp_latch_in = 1'b1;
        cyc(wl);
        jp_latch_in = 1'b0;
        cyc(5);
        m_val = b;
        n1 = 0;
        n2 = 0;
    endtask

    task automatic pulse(input int wlo, input int whi);
        jp_clk_in = 1'b0;
        cyc(wlo);
        n2++;
        jp_clk_in = 1'b1;
        cyc(whi);
        n1++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        turbo_en_in = 2'b00;
        for (int i = 0; i < 6; i++) begin
            jp_latch_in = 1'($urandom);
            jp_clk_in   = 1'($urandom);
            buttons_in  = 8'($urandom);
            turbo_en_in = 2'($urandom);
            cyc(1);
        end
        total++; if (d1_data !== 1'b1) begin bad++; $display("FAIL rst_data got=%b exp=1", d1_data); end
        total++; if (d1_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", d1_cnt); end
        total++; if (d1_frame !== 1'b0) begin bad++; $display("FAIL rst_frame got=%b exp=0", d1_frame); end
        total++; if (d2_data !== 1'b0) begin bad++; $display("FAIL rst_data2 got=%b exp=0", d2_data); end
        jp_latch_in = 1'b0;
        jp_clk_in   = 1'b1;
        buttons_in  = 8'h00;
        turbo_en_in = 2'b00;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        total++; if (d1_data !== 1'b1) begin bad++; $display("FAIL post_rst_data got=%b exp=1", d1_data); end
        total++; if (d1_cnt !== 4'd0) begin bad++; $display("FAIL post_rst_cnt got=%0d exp=0", d1_cnt); end
        total++; if (d2_cnt !== 4'd0) begin bad++; $display("FAIL post_rst_cnt2 got=%0d exp=0", d2_cnt); end
        total++; if (strobes != 0) begin bad++; $display("FAIL post_rst_strobe got=%0d exp=0", strobes); end
    endtask

    task automatic test_basic_frame;
        int s0;
        buttons_in = 8'b1001_0101;
        cyc(4);
        jp_latch_in = 1'b1;
        cyc(10);
        total++; if (d1_data !== 1'b0) begin bad++; $display("FAIL basic_load_data got=%b exp=0", d1_data); end
        total++; if (d1_cnt !== 4'd0) begin bad++; $display("FAIL basic_load_cnt got=%0d exp=0", d1_cnt); end
        s0 = strobes;
        jp_latch_in = 1'b0;
        cyc(2);
        total++; if (d1_frame !== 1'b0) begin bad++; $display("FAIL strobe_early got=%b exp=0", d1_frame); end
        cyc(1);
        total++; if (d1_frame !== 1'b1) begin bad++; $display("FAIL strobe_on got=%b exp=1", d1_frame); end
        cyc(1);
        total++; if (d1_frame !== 1'b0) begin bad++; $display("FAIL strobe_off got=%b exp=0", d1_frame); end
        cyc(3);
        m_val = 8'b1001_0101;
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 8; i++) begin
            jp_clk_in = 1'b0;
            cyc(6);
            n2++;
            jp_clk_in = 1'b1;
            cyc(2);
            total++; if (d1_data !== ~mbit(n1)) begin bad++; $display("FAIL basic_latency_old%0d got=%b exp=%b", i, d1_data, ~mbit(n1)); end
            cyc(1);
            n1++;
            total++; if (d1_data !== ~mbit(n1)) begin bad++; $display("FAIL basic_bit%0d got=%b exp=%b", i, d1_data, ~mbit(n1)); end
            total++; if (d1_cnt !== sat8(n1)) begin bad++; $display("FAIL basic_cnt%0d got=%0d exp=%0d", i, d1_cnt, sat8(n1)); end
            cyc(3);
        end
        total++; if (strobes != s0 + 1) begin bad++; $display("FAIL basic_strobes got=%0d exp=%0d", strobes, s0 + 1); end
    endtask

    task automatic test_overrun;
        do_latch(8'h00, 6);
        for (int i = 0; i < 12; i++) begin
            pulse($urandom_range(4, 8), $urandom_range(4, 8));
            total++; if (d1_data !== ~mbit(n1)) begin bad++; $display("FAIL overrun_bit%0d got=%b exp=%b", i, d1_data, ~mbit(n1)); end
            total++; if (d1_cnt !== sat8(n1)) begin bad++; $display("FAIL overrun_cnt%0d got=%0d exp=%0d", i, d1_cnt, sat8(n1)); end
            total++; if (d2_cnt !== sat8(n2)) begin bad++; $display("FAIL overrun_cnt2_%0d got=%0d exp=%0d", i, d2_cnt, sat8(n2)); end
        end
    endtask

    task automatic test_random_frames;
        logic [7:0] b;
        int np;
        for (int f = 0; f < 8; f++) begin
            b = 8'($urandom);
            do_latch(b, $urandom_range(4, 12));
            total++; if (d1_data !== ~b[0]) begin bad++; $display("FAIL rnd_a%0d got=%b exp=%b", f, d1_data, ~b[0]); end
            np = $urandom_range(0, 11);
            for (int i = 0; i < np; i++) begin
                pulse($urandom_range(4, 9), $urandom_range(4, 9));
                total++; if (d1_data !== ~mbit(n1)) begin bad++; $display("FAIL rnd_bit%0d_%0d got=%b exp=%b", f, i, d1_data, ~mbit(n1)); end
                total++; if (d1_cnt !== sat8(n1)) begin bad++; $display("FAIL rnd_cnt%0d_%0d got=%0d exp=%0d", f, i, d1_cnt, sat8(n1)); end
                total++; if (d2_data !== mbit(n2)) begin bad++; $display("FAIL rnd_bit2_%0d_%0d got=%b exp=%b", f, i, d2_data, mbit(n2)); end
            end
        end
    endtask

    task automatic test_relatch;
        logic [7:0] b;
        logic [7:0] nb;
        b  = 8'($urandom);
        nb = ~b;
        do_latch(b, 6);
        for (int i = 0; i < 3; i++) begin
            pulse(5, 5);
            total++; if (d1_data !== ~mbit(n1)) begin bad++; $display("FAIL relatch_pre%0d got=%b exp=%b", i, d1_data, ~mbit(n1)); end
        end
        buttons_in = nb;
        cyc(4);
        total++; if (d1_cnt !== 4'd3) begin bad++; $display("FAIL relatch_hold_cnt got=%0d exp=3", d1_cnt); end
        total++; if (d1_data !== ~mbit(n1)) begin bad++; $display("FAIL relatch_no_reload got=%b exp=%b", d1_data, ~mbit(n1)); end
        jp_latch_in = 1'b1;
        cyc(3);
        total++; if (d1_cnt !== 4'd0) begin bad++; $display("FAIL relatch_cnt got=%0d exp=0", d1_cnt); end
        total++; if (d1_data !== ~nb[0]) begin bad++; $display("FAIL relatch_a got=%b exp=%b", d1_data, ~nb[0]); end
        for (int i = 0; i < 3; i++) begin
            jp_clk_in = 1'b0;
            cyc(4);
            jp_clk_in = 1'b1;
            cyc(4);
            total++; if (d1_cnt !== 4'd0) begin bad++; $display("FAIL latched_clk_cnt%0d got=%0d exp=0", i, d1_cnt); end
            total++; if (d1_data !== ~nb[0]) begin bad++; $display("FAIL latched_clk_data%0d got=%b exp=%b", i, d1_data, ~nb[0]); end
        end
        jp_latch_in = 1'b0;
        cyc(5);
        m_val = nb;
        n1 = 0;
        n2 = 0;
        pulse(5, 5);
        total++; if (d1_data !== ~mbit(1)) begin bad++; $display("FAIL relatch_first_shift got=%b exp=%b", d1_data, ~mbit(1)); end
        total++; if (d1_cnt !== 4'd1) begin bad++; $display("FAIL relatch_first_cnt got=%0d exp=1", d1_cnt); end
    endtask

    task automatic test_turbo;
        int k;
        logic expa;
        buttons_in  = 8'h03;
        turbo_en_in = 2'b01;
        jp_latch_in = 1'b1;
        cyc(4);
        // Turbo phase after j clocks is 1 for j in [0,16), 0 for [16,32), ...
        for (int i = 0; i < 48; i++) begin
            cyc(1);
            k = tcyc;
            expa = ~(1'(((k - 1) >> 4) & 1));
            total++; if (d1_data !== ~expa) begin bad++; $display("FAIL turbo_a%0d got=%b exp=%b", i, d1_data, ~expa); end
        end
        for (int f = 0; f < 4; f++) begin
            jp_latch_in = 1'b0;
            cyc(5);
            m_val = 8'h03;
            n1 = 0;
            n2 = 0;
            pulse(4, 4);
            total++; if (d1_data !== 1'b0) begin bad++; $display("FAIL turbo_b%0d got=%b exp=0", f, d1_data); end
            jp_latch_in = 1'b1;
            cyc($urandom_range(4, 20));
        end
        jp_latch_in = 1'b0;
        turbo_en_in = 2'b00;
        cyc(5);
    endtask

    task automatic test_polarity;
        logic [7:0] b;
        b = 8'($urandom);
        do_latch(b, 6);
        total++; if (d2_data !== b[0]) begin bad++; $display("FAIL pol_a got=%b exp=%b", d2_data, b[0]); end
        for (int i = 0; i < 8; i++) begin
            jp_clk_in = 1'b0;
            cyc(4);
            n2++;
            total++; if (d2_data !== mbit(n2)) begin bad++; $display("FAIL pol_fall_bit%0d got=%b exp=%b", i, d2_data, mbit(n2)); end
            total++; if (d2_cnt !== sat8(n2)) begin bad++; $display("FAIL pol_fall_cnt%0d got=%0d exp=%0d", i, d2_cnt, sat8(n2)); end
            total++; if (d1_cnt !== sat8(n1)) begin bad++; $display("FAIL pol_rise_idle%0d got=%0d exp=%0d", i, d1_cnt, sat8(n1)); end
            jp_clk_in = 1'b1;
            cyc(4);
            n1++;
            total++; if (d2_cnt !== sat8(n2)) begin bad++; $display("FAIL pol_no_rise_shift%0d got=%0d exp=%0d", i, d2_cnt, sat8(n2)); end
            total++; if (d2_data !== mbit(n2)) begin bad++; $display("FAIL pol_hold_bit%0d got=%b exp=%b", i, d2_data, mbit(n2)); end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        buttons_in  = 8'h00;
        turbo_en_in = 2'b00;
        jp_latch_in = 1'b0;
        jp_clk_in   = 1'b1;
        m_val       = 8'h00;
        n1          = 0;
        n2          = 0;
        test_reset();
        test_basic_frame();
        test_overrun();
        test_random_frames();
        test_relatch();
        test_turbo();
        test_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
